uarc_receiver_arbiter: RTL
==========================

UARC_RECEIVER_ARBITER -- requirements
Module: uarc_receiver_arbiter

Interface
REQ-001 SHALL have parameter WORD_MAG, default 5; word width WORD_WIDTH = 1 << WORD_MAG.
REQ-002 SHALL have parameter TOTAL_BUSES, default 4, legal range 1..64; bus index width BI = max(1, clog2(TOTAL_BUSES)).
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 receiver_enables  input  TOTAL_BUSES  per-bus sender-present qualifier.
REQ-006 receiver_kills, receiver_incepts, receiver_sends, receiver_streams  input  TOTAL_BUSES each  per-bus message requests.
REQ-007 receiver_datas  input  TOTAL_BUSES x WORD_WIDTH  per-bus data word, packed, bus 0 in the LSBs.
REQ-008 receiver_kill_acks, receiver_incept_acks, receiver_send_acks, receiver_stream_acks  output  TOTAL_BUSES each  one-cycle acknowledge pulses.
REQ-009 msg_valid  output  1  a granted message is presented to the core.
REQ-010 msg_kind  output  2  0=kill, 1=incept, 2=send, 3=stream.
REQ-011 msg_bus  output  BI  index of the granted bus.
REQ-012 msg_data  output  WORD_WIDTH  data word captured from the granted bus.
REQ-013 msg_ready  input  1  core accepts the presented message.

Function
REQ-014 Bus i SHALL request when receiver_enables[i] is high and any of its four request bits is high.
REQ-015 Within one bus, kind priority SHALL be kill > incept > send > stream.
REQ-016 Across buses, arbitration SHALL be round-robin: search starts at pointer rr_ptr, ascending with wrap-around from TOTAL_BUSES-1 to 0.
REQ-017 State machine SHALL have three states: IDLE, PRESENT, ACK.
REQ-018 IDLE: if any bus requests at edge N, register the winner's bus index, kind and data, and enter PRESENT; msg_valid SHALL be high from cycle N+1 (latency 1); with no request, remain in IDLE.
REQ-019 PRESENT: msg_valid is high, and msg_kind/msg_bus/msg_data SHALL hold stable; when msg_ready is high at an edge, enter ACK.
REQ-020 ACK: for exactly one cycle, msg_valid SHALL be low and exactly one bit SHALL be high: the ack bit of the granted kind and bus; then enter IDLE.
REQ-021 On leaving ACK, rr_ptr SHALL become (granted bus + 1) mod TOTAL_BUSES; rr_ptr SHALL be unchanged otherwise.
REQ-022 Requests sampled during PRESENT or ACK SHALL NOT change the grant; a new arbitration occurs only in IDLE, so back-to-back grants are spaced at least 3 cycles apart.
REQ-023 Abort: in PRESENT, if the granted bus's receiver_enables bit or its granted request bit is low at an edge, return to IDLE with no ack pulse and rr_ptr unchanged; this check SHALL take precedence over msg_ready in the same cycle.
REQ-024 A higher-priority kind arriving on the granted bus during PRESENT SHALL NOT preempt the grant.
REQ-025 All ack outputs SHALL be zero in every state except ACK.
REQ-026 With TOTAL_BUSES=1, rr_ptr SHALL remain 0 and msg_bus SHALL be 0.

Reset
REQ-027 While reset is high, the block SHALL be in IDLE: rr_ptr=0, msg_valid=0, msg_kind=0, msg_bus=0, msg_data=0, and all acks 0, asynchronously.
REQ-028 Reset asserted in PRESENT or ACK SHALL drop msg_valid and any ack immediately, with no ack pulse completing.
REQ-029 The first arbitration after reset deassertion SHALL occur at the first edge at which reset is low.

Verification
REQ-030 Bus 2 asserts send, enable=1, data=0xDEADBEEF, msg_ready tied high -> msg_valid, kind=2, bus=2, data=0xDEADBEEF one cycle later; receiver_send_acks=0b0100 for exactly one cycle; rr_ptr=3.
REQ-031 Buses 0..3 all send continuously, ready=1 -> grant order 0,1,2,3,0; each ack is one cycle; grants are 3 cycles apart.
REQ-032 Bus 1 asserts kill, incept and stream together -> kind=0, receiver_kill_acks=0b0010 only; on the next grant (kill removed) -> kind=1.
REQ-033 In PRESENT with msg_ready low, the granted bus drops enable -> msg_valid falls next cycle, no ack, rr_ptr unchanged.
REQ-034 Reset pulse mid-PRESENT and mid-ACK -> all outputs 0 immediately; rr_ptr=0; arbitration resumes after release.
REQ-035 In PRESENT, msg_ready is held low for 10 cycles while other buses request -> outputs stay stable, no other ack, grant unchanged.

Source files
------------

// File: rtl/uarc_receiver_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uarc_receiver_arbiter
// Brief    : Round-robin arbiter across receiver buses with per-bus kind
//            priority, present/accept handshake and one-cycle ack pulse.
// Revision : 1.0 - initial release
// ============================================================================
module uarc_receiver_arbiter #(
   parameter int WORD_MAG    = 5,
   parameter int TOTAL_BUSES = 4,
   localparam int WORD_WIDTH = 1 << WORD_MAG,
   localparam int BI         = (TOTAL_BUSES > 1) ? $clog2(TOTAL_BUSES) : 1
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic [TOTAL_BUSES-1:0]            receiver_enables,
   input  logic [TOTAL_BUSES-1:0]            receiver_kills,
   input  logic [TOTAL_BUSES-1:0]            receiver_incepts,
   input  logic [TOTAL_BUSES-1:0]            receiver_sends,
   input  logic [TOTAL_BUSES-1:0]            receiver_streams,
   input  logic [TOTAL_BUSES*WORD_WIDTH-1:0] receiver_datas,
   output logic [TOTAL_BUSES-1:0]            receiver_kill_acks,
   output logic [TOTAL_BUSES-1:0]            receiver_incept_acks,
   output logic [TOTAL_BUSES-1:0]            receiver_send_acks,
   output logic [TOTAL_BUSES-1:0]            receiver_stream_acks,
   output logic                              msg_valid,
   output logic [1:0]                        msg_kind,
   output logic [BI-1:0]                     msg_bus,
   output logic [WORD_WIDTH-1:0]             msg_data,
   input  logic                              msg_ready
);

   localparam logic [1:0]  S_IDLE    = 2'd0;
   localparam logic [1:0]  S_PRESENT = 2'd1;
   localparam logic [1:0]  S_ACK     = 2'd2;

   localparam int          BIP        = BI + 1;
   localparam logic [BI:0] c_total    = BIP'(TOTAL_BUSES);
   localparam logic [BI-1:0] c_last_bus = BI'(TOTAL_BUSES - 1);
   localparam logic [BI-1:0] c_one      = BI'(1);

   logic [1:0]            r_state;
   logic [1:0]            w_next_state;
   logic [BI-1:0]         r_rr_ptr;
   logic [1:0]            r_kind;
   logic [BI-1:0]         r_bus;
   logic [WORD_WIDTH-1:0] r_data;

   logic [TOTAL_BUSES-1:0] w_req;
   logic                   w_found;
   logic [BI-1:0]          w_win_bus;
   logic [BI:0]            w_idx;
   logic [1:0]             w_win_kind;
   logic [WORD_WIDTH-1:0]  w_win_data;
   logic                   w_granted_req;
   logic                   w_abort;

   assign w_req = receiver_enables &
                  (receiver_kills | receiver_incepts | receiver_sends | receiver_streams);

   // First requesting bus at or after rr_ptr, wrapping past the last bus.
   always_comb begin
      w_found   = 1'b0;
      w_win_bus = '0;
      w_idx     = '0;
      for (int k = 0; k < TOTAL_BUSES; k++) begin
         w_idx = {1'b0, r_rr_ptr} + BIP'(k);
         if (w_idx >= c_total)
            w_idx = w_idx - c_total;
         if (!w_found && w_req[w_idx[BI-1:0]]) begin
            w_found   = 1'b1;
            w_win_bus = w_idx[BI-1:0];
         end
      end
   end

   always_comb begin
      if (receiver_kills[w_win_bus])
         w_win_kind = 2'd0;
      else if (receiver_incepts[w_win_bus])
         w_win_kind = 2'd1;
      else if (receiver_sends[w_win_bus])
         w_win_kind = 2'd2;
      else
         w_win_kind = 2'd3;
      w_win_data = receiver_datas[int'(w_win_bus)*WORD_WIDTH +: WORD_WIDTH];
   end

   // The grant is withdrawn if its sender or the specific granted request goes away.
   always_comb begin
      case (r_kind)
         2'd0:    w_granted_req = receiver_kills[r_bus];
         2'd1:    w_granted_req = receiver_incepts[r_bus];
         2'd2:    w_granted_req = receiver_sends[r_bus];
         default: w_granted_req = receiver_streams[r_bus];
      endcase
      w_abort = !(receiver_enables[r_bus] && w_granted_req);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         r_state <= S_IDLE;
      else
         r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE:    if (w_found) w_next_state = S_PRESENT;
         S_PRESENT: begin
            if (w_abort)
               w_next_state = S_IDLE;
            else if (msg_ready)
               w_next_state = S_ACK;
         end
         S_ACK:     w_next_state = S_IDLE;
         default:   w_next_state = S_IDLE;
      endcase
   end

   always_comb begin
      msg_valid            = (r_state == S_PRESENT);
      receiver_kill_acks   = '0;
      receiver_incept_acks = '0;
      receiver_send_acks   = '0;
      receiver_stream_acks = '0;
      if (r_state == S_ACK) begin
         case (r_kind)
            2'd0:    receiver_kill_acks[r_bus]   = 1'b1;
            2'd1:    receiver_incept_acks[r_bus] = 1'b1;
            2'd2:    receiver_send_acks[r_bus]   = 1'b1;
            default: receiver_stream_acks[r_bus] = 1'b1;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_rr_ptr <= '0;
         r_kind   <= '0;
         r_bus    <= '0;
         r_data   <= '0;
      end else begin
         if (r_state == S_IDLE && w_found) begin
            r_kind <= w_win_kind;
            r_bus  <= w_win_bus;
            r_data <= w_win_data;
         end
         if (r_state == S_ACK)
            r_rr_ptr <= (r_bus == c_last_bus) ? '0 : r_bus + c_one;
      end
   end

   assign msg_kind = r_kind;
   assign msg_bus  = r_bus;
   assign msg_data = r_data;

endmodule
`default_nettype wire
